// File: rtl/bitpack_pkg.sv
// Shared widths, FSM state type and length clamp for the bitstream packer.
package bitpack_pkg;

  localparam int DATA_W = 128;
  localparam int ACC_W  = 255;
  localparam int LEN_W  = 8;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_t;

  // Lengths above one codec word are illegal and treated as a full word.
  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
    logic [LEN_W-1:0] max_len;
    max_len = LEN_W'(DATA_W);
    return (len > max_len) ? max_len : len;
  endfunction

endpackage

// File: rtl/bitpack_insert.sv
// Masks an MSB-aligned syntax element to its length and positions it under
// the accumulator fill pointer, ready to be OR'd into the accumulator.
module bitpack_insert
  import bitpack_pkg::*;
(
  input  logic [DATA_W-1:0] i_data,
  input  logic [LEN_W-1:0]  i_len,
  input  logic [LEN_W-1:0]  i_ptr,
  output logic [ACC_W-1:0]  o_field
);

  logic [DATA_W-1:0] w_mask;
  logic [DATA_W-1:0] w_masked;
  logic [ACC_W-1:0]  w_aligned;

  // i_len is pre-clamped to 0..128; a shift by 128 yields an all-ones mask.
  assign w_mask    = ~({DATA_W{1'b1}} >> i_len);
  assign w_masked  = i_data & w_mask;
  assign w_aligned = {w_masked, {(ACC_W-DATA_W){1'b0}}};
  assign o_field   = w_aligned >> i_ptr;

endmodule

// File: rtl/bitpack.sv
// Encoder bitstream packer: concatenates MSB-aligned syntax elements into
// 128-bit codec words. Optional bit/pad counters under BITPACK_BITCNT_EN.
module bitpack
  import bitpack_pkg::*;
(
  input  logic              clk,
  input  logic              rstn,
  input  logic              se_vld,
  output logic              se_rdy,
  input  logic [DATA_W-1:0] se_data,
  input  logic [LEN_W-1:0]  se_len,
  input  logic              flush_req,
  output logic              flush_done,
  input  logic              codec_data_full,
  output logic              codec_data_wr_en,
  output logic [DATA_W-1:0] codec_data,
  output logic [LEN_W-1:0]  fullness,
  output logic              o_dbg_state
`ifdef BITPACK_BITCNT_EN
  ,
  output logic [31:0]       bit_cnt,
  output logic [7:0]        pad_cnt
`endif
);

  localparam logic [LEN_W-1:0] WORD_BITS = LEN_W'(DATA_W);
  localparam logic [LEN_W-1:0] MAX_PTR   = WORD_BITS - 8'd1;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [ACC_W-1:0] r_acc;
  logic [ACC_W-1:0] w_acc_sh;
  logic [ACC_W-1:0] w_acc_nxt;
  logic [ACC_W-1:0] w_field;
  logic [LEN_W-1:0] r_fullness;
  logic [LEN_W-1:0] w_fullness_nxt;
  logic [LEN_W-1:0] w_drain_bits;
  logic [LEN_W-1:0] w_f_eff;
  logic [LEN_W-1:0] w_len_c;
  logic             w_drain;
  logic             w_accept;
  logic             w_flush_done;

  // Drain: a full word in RUN, or any remaining bits (zero-padded) in FLUSH.
  always_comb begin
    w_drain = 1'b0;
    if (r_state == RUN) begin
      w_drain = (r_fullness >= WORD_BITS) && !codec_data_full;
    end else begin
      w_drain = (r_fullness != '0) && !codec_data_full;
    end
  end

  assign w_drain_bits = !w_drain ? '0 :
                        ((r_fullness >= WORD_BITS) ? WORD_BITS : r_fullness);
  assign w_f_eff      = r_fullness - w_drain_bits;
  assign w_acc_sh     = w_drain ? (r_acc << DATA_W) : r_acc;

  // Handshake: an element transfers on a cycle where se_vld && se_rdy. se_rdy
  // is combinational (it sees this cycle's drain, hence codec_data_full) and
  // is independent of se_vld; once se_vld is raised the element is held until
  // that transfer cycle.
  assign se_rdy   = (r_state == RUN) && (w_f_eff <= MAX_PTR);
  assign w_accept = se_vld && se_rdy;
  assign w_len_c  = clamp_len(se_len);

  bitpack_insert u_insert (
    .i_data  (se_data),
    .i_len   (w_len_c),
    .i_ptr   (w_f_eff),
    .o_field (w_field)
  );

  assign w_acc_nxt      = w_accept ? (w_acc_sh | w_field) : w_acc_sh;
  assign w_fullness_nxt = w_accept ? (w_f_eff + w_len_c) : w_f_eff;

  always_comb begin
    w_state_nxt  = r_state;
    w_flush_done = 1'b0;
    case (r_state)
      RUN: begin
        if (flush_req) begin
          w_state_nxt = FLUSH;
        end
      end
      FLUSH: begin
        // Empty accumulator means nothing left to drain.
        if (r_fullness == '0) begin
          w_flush_done = 1'b1;
          w_state_nxt  = RUN;
        end
      end
      default: w_state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= RUN;
      r_acc      <= '0;
      r_fullness <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_acc      <= w_acc_nxt;
      r_fullness <= w_fullness_nxt;
    end
  end

  assign codec_data       = r_acc[ACC_W-1 -: DATA_W];
  assign codec_data_wr_en = w_drain;
  assign flush_done       = w_flush_done;
  assign fullness         = r_fullness;
  assign o_dbg_state      = (r_state == FLUSH);

`ifdef BITPACK_BITCNT_EN
  logic [31:0] r_bit_cnt;
  logic [32:0] w_bit_sum;
  logic [7:0]  r_pad_pend;
  logic [7:0]  r_pad_cnt;

  assign w_bit_sum = {1'b0, r_bit_cnt} + 33'(w_len_c);

  // Pad count of a flush is known at its partial-word drain and published
  // once the flush completes.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_bit_cnt  <= '0;
      r_pad_pend <= '0;
      r_pad_cnt  <= '0;
    end else begin
      if (w_accept) begin
        r_bit_cnt <= w_bit_sum[32] ? 32'hFFFF_FFFF : w_bit_sum[31:0];
      end
      if ((r_state == RUN) && flush_req) begin
        r_pad_pend <= '0;
      end else if ((r_state == FLUSH) && w_drain && (r_fullness < WORD_BITS)) begin
        r_pad_pend <= WORD_BITS - r_fullness;
      end
      if (w_flush_done) begin
        r_pad_cnt <= r_pad_pend;
      end
    end
  end

  assign bit_cnt = r_bit_cnt;
  assign pad_cnt = r_pad_cnt;
`else
  // Counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_bitpack.sv
// Self-checking bench for bitpack: directed scenarios plus a random stream
// checked against a bit-queue reference model.
`timescale 1ns/1ps
module tb_bitpack;

  logic         clk;
  logic         rstn;
  logic         se_vld;
  logic         se_rdy;
  logic [127:0] se_data;
  logic [7:0]   se_len;
  logic         flush_req;
  logic         flush_done;
  logic         codec_data_full;
  logic         codec_data_wr_en;
  logic [127:0] codec_data;
  logic [7:0]   fullness;
  logic         dbg_state;
`ifdef BITPACK_BITCNT_EN
  logic [31:0]  bit_cnt;
  logic [7:0]   pad_cnt;
  logic [7:0]   model_pad;
`endif

  int           n_compared;
  int           n_mismatch;
  logic [127:0] exp_q[$];
  logic [127:0] got_q[$];
  bit           model_bits[$];
  logic [31:0]  exp_bits;
  logic [127:0] w_got;
  logic [127:0] w_exp;
  bit           bp_en;

  bitpack u_dut (
    .clk              (clk),
    .rstn             (rstn),
    .se_vld           (se_vld),
    .se_rdy           (se_rdy),
    .se_data          (se_data),
    .se_len           (se_len),
    .flush_req        (flush_req),
    .flush_done       (flush_done),
    .codec_data_full  (codec_data_full),
    .codec_data_wr_en (codec_data_wr_en),
    .codec_data       (codec_data),
    .fullness         (fullness),
    .o_dbg_state      (dbg_state)
`ifdef BITPACK_BITCNT_EN
    ,
    .bit_cnt          (bit_cnt),
    .pad_cnt          (pad_cnt)
`endif
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Output monitor: capture every written word for the scoreboard.
  always @(negedge clk) begin
    if (codec_data_wr_en === 1'b1) got_q.push_back(codec_data);
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [127:0] d, input logic [7:0] l);
    int n;
    n = 0;
    se_vld = 1'b1; se_data = d; se_len = l;
    forever begin
      @(negedge clk);
      if (se_rdy === 1'b1) break;
      @(posedge clk); #1;
      if (bp_en) codec_data_full = ($urandom_range(0, 3) == 0);
      n++;
      if (n > 200) begin
        n_compared++; n_mismatch++;
        $display("FAIL send_timeout: se_rdy stayed %b, wanted 1 within 200 cycles", se_rdy);
        break;
      end
    end
    @(posedge clk); #1;
    se_vld = 1'b0;
    exp_bits = exp_bits + ((l > 8'd128) ? 32'd128 : 32'(l));
    if (bp_en) codec_data_full = ($urandom_range(0, 3) == 0);
  endtask

  task automatic do_flush(output int lat);
    flush_req = 1'b1;
    @(posedge clk); #1;
    flush_req = 1'b0;
    lat = 0;
    while (flush_done !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    if (lat >= 40) begin
      n_compared++; n_mismatch++;
      $display("FAIL flush_timeout: flush_done=%b, wanted 1 within 40 cycles", flush_done);
    end
    @(posedge clk); #1;
  endtask

  // ---------------- reference model ----------------
  task automatic model_push(input logic [127:0] d, input logic [7:0] l);
    int lc;
    logic [127:0] w;
    lc = (l > 8'd128) ? 128 : int'(l);
    for (int i = 0; i < lc; i++) model_bits.push_back(d[127-i]);
    while (model_bits.size() >= 128) begin
      for (int i = 0; i < 128; i++) w[127-i] = model_bits.pop_front();
      exp_q.push_back(w);
    end
  endtask

  task automatic model_flush();
    logic [127:0] w;
    int i;
    w = '0;
`ifdef BITPACK_BITCNT_EN
    model_pad = 8'd0;
    if (model_bits.size() > 0) model_pad = 8'(128 - model_bits.size());
`endif
    if (model_bits.size() > 0) begin
      i = 0;
      while (model_bits.size() > 0) begin
        w[127-i] = model_bits.pop_front();
        i++;
      end
      exp_q.push_back(w);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rstn = 1'b0; se_vld = 1'b0; se_data = '0; se_len = '0;
    flush_req = 1'b0; codec_data_full = 1'b0; bp_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_compared++; if (se_rdy !== 1'b1) begin n_mismatch++; $display("FAIL reset_rdy: got %b want 1", se_rdy); end
    n_compared++; if (codec_data_wr_en !== 1'b0) begin n_mismatch++; $display("FAIL reset_wr_en: got %b want 0", codec_data_wr_en); end
    n_compared++; if (codec_data !== 128'h0) begin n_mismatch++; $display("FAIL reset_data: got %h want 0", codec_data); end
    n_compared++; if (flush_done !== 1'b0) begin n_mismatch++; $display("FAIL reset_flush_done: got %b want 0", flush_done); end
    n_compared++; if (fullness !== 8'd0) begin n_mismatch++; $display("FAIL reset_fullness: got %0d want 0", fullness); end
    @(negedge clk); rstn = 1'b1;
    @(posedge clk); #1;
    exp_bits = 32'd0;
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_pack32();
    logic [127:0] word;
    word = 128'hAAAAAAAA_55555555_12345678_9ABCDEF0;
    exp_q.push_back(word);
    send({32'hAAAAAAAA, 96'h0}, 8'd32);
    send({32'h55555555, 96'h0}, 8'd32);
    send({32'h12345678, 96'h0}, 8'd32);
    send({32'h9ABCDEF0, 96'h0}, 8'd32);
    n_compared++; if (codec_data_wr_en !== 1'b1) begin n_mismatch++; $display("FAIL pack32_wr_en: got %b want 1", codec_data_wr_en); end
    n_compared++; if (codec_data !== word) begin n_mismatch++; $display("FAIL pack32_data: got %h want %h", codec_data, word); end
    @(posedge clk); #1;
    n_compared++; if (fullness !== 8'd0) begin n_mismatch++; $display("FAIL pack32_fullness: got %0d want 0", fullness); end
    n_compared++; if (got_q.size() != exp_q.size()) begin n_mismatch++; $display("FAIL pack32_words: got %0d want %0d", got_q.size(), exp_q.size()); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      w_got = got_q.pop_front(); w_exp = exp_q.pop_front(); n_compared++;
      if (w_got !== w_exp) begin n_mismatch++; $display("FAIL pack32_word: got %h want %h", w_got, w_exp); end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_mixed_len();
    int lat;
    exp_q.push_back({48'hFFFF_FFFF_FFFF, 80'h0});
    exp_q.push_back(128'h0);
    send({128{1'b1}}, 8'd48);
    send({100'h0, 28'hFFFFFFF}, 8'd100);
    n_compared++; if (fullness !== 8'd148) begin n_mismatch++; $display("FAIL mixed_fullness148: got %0d want 148", fullness); end
    @(posedge clk); #1;
    n_compared++; if (fullness !== 8'd20) begin n_mismatch++; $display("FAIL mixed_fullness20: got %0d want 20", fullness); end
    do_flush(lat);
    n_compared++; if (got_q.size() != exp_q.size()) begin n_mismatch++; $display("FAIL mixed_words: got %0d want %0d", got_q.size(), exp_q.size()); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      w_got = got_q.pop_front(); w_exp = exp_q.pop_front(); n_compared++;
      if (w_got !== w_exp) begin n_mismatch++; $display("FAIL mixed_word: got %h want %h", w_got, w_exp); end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_flush();
    logic [127:0] word;
    word = {20'hABCDE, 108'h0};
    send(word, 8'd20);
    n_compared++; if (fullness !== 8'd20) begin n_mismatch++; $display("FAIL flush_pre_fullness: got %0d want 20", fullness); end
    exp_q.push_back(word);
    flush_req = 1'b1;
    @(posedge clk); #1;
    flush_req = 1'b0;
    n_compared++; if (dbg_state !== 1'b1) begin n_mismatch++; $display("FAIL flush_state: got %b want 1", dbg_state); end
    n_compared++; if (se_rdy !== 1'b0) begin n_mismatch++; $display("FAIL flush_rdy: got %b want 0", se_rdy); end
    n_compared++; if (codec_data_wr_en !== 1'b1) begin n_mismatch++; $display("FAIL flush_wr_en: got %b want 1", codec_data_wr_en); end
    n_compared++; if (codec_data !== word) begin n_mismatch++; $display("FAIL flush_data: got %h want %h", codec_data, word); end
    n_compared++; if (flush_done !== 1'b0) begin n_mismatch++; $display("FAIL flush_done_early: got %b want 0", flush_done); end
    @(posedge clk); #1;
    n_compared++; if (flush_done !== 1'b1) begin n_mismatch++; $display("FAIL flush_done: got %b want 1", flush_done); end
    n_compared++; if (codec_data_wr_en !== 1'b0) begin n_mismatch++; $display("FAIL flush_wr_en_after: got %b want 0", codec_data_wr_en); end
    @(posedge clk); #1;
    n_compared++; if (se_rdy !== 1'b1) begin n_mismatch++; $display("FAIL flush_rdy_after: got %b want 1", se_rdy); end
`ifdef BITPACK_BITCNT_EN
    n_compared++; if (pad_cnt !== 8'd108) begin n_mismatch++; $display("FAIL flush_pad_cnt: got %0d want 108", pad_cnt); end
`endif
    n_compared++; if (got_q.size() != exp_q.size()) begin n_mismatch++; $display("FAIL flush_words: got %0d want %0d", got_q.size(), exp_q.size()); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      w_got = got_q.pop_front(); w_exp = exp_q.pop_front(); n_compared++;
      if (w_got !== w_exp) begin n_mismatch++; $display("FAIL flush_word: got %h want %h", w_got, w_exp); end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_flush_empty();
    int lat;
    do_flush(lat);
    n_compared++; if (lat != 0) begin n_mismatch++; $display("FAIL flush_empty_latency: got %0d want 0", lat); end
    n_compared++; if (got_q.size() != 0) begin n_mismatch++; $display("FAIL flush_empty_words: got %0d want 0", got_q.size()); end
`ifdef BITPACK_BITCNT_EN
    n_compared++; if (pad_cnt !== 8'd0) begin n_mismatch++; $display("FAIL flush_empty_pad: got %0d want 0", pad_cnt); end
`endif
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_backpressure();
    logic [127:0] x, y;
    int lat;
    x = {$urandom, $urandom, $urandom, $urandom};
    y = {$urandom, $urandom, $urandom, $urandom};
    exp_q.push_back({x[127:28], y[127:100]});
    exp_q.push_back({y[99:28], 56'h0});
    codec_data_full = 1'b1;
    send(x, 8'd100);
    send(y, 8'd100);
    repeat (3) begin
      n_compared++; if (fullness !== 8'd200) begin n_mismatch++; $display("FAIL bp_fullness_hold: got %0d want 200", fullness); end
      n_compared++; if (se_rdy !== 1'b0 || codec_data_wr_en !== 1'b0) begin n_mismatch++; $display("FAIL bp_hold: rdy=%b wr_en=%b want 0 0", se_rdy, codec_data_wr_en); end
      @(posedge clk); #1;
    end
    n_compared++; if (codec_data !== {x[127:28], y[127:100]}) begin n_mismatch++; $display("FAIL bp_data_hold: got %h want %h", codec_data, {x[127:28], y[127:100]}); end
    codec_data_full = 1'b0;
    #1;
    n_compared++; if (codec_data_wr_en !== 1'b1 || se_rdy !== 1'b1) begin n_mismatch++; $display("FAIL bp_release: wr_en=%b rdy=%b want 1 1", codec_data_wr_en, se_rdy); end
    @(posedge clk); #1;
    n_compared++; if (fullness !== 8'd72) begin n_mismatch++; $display("FAIL bp_fullness72: got %0d want 72", fullness); end
    do_flush(lat);
`ifdef BITPACK_BITCNT_EN
    n_compared++; if (pad_cnt !== 8'd56) begin n_mismatch++; $display("FAIL bp_pad_cnt: got %0d want 56", pad_cnt); end
`endif
    n_compared++; if (got_q.size() != exp_q.size()) begin n_mismatch++; $display("FAIL bp_words: got %0d want %0d", got_q.size(), exp_q.size()); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      w_got = got_q.pop_front(); w_exp = exp_q.pop_front(); n_compared++;
      if (w_got !== w_exp) begin n_mismatch++; $display("FAIL bp_word: got %h want %h", w_got, w_exp); end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_zero_clamp();
    exp_q.push_back({128{1'b1}});
    send({128{1'b1}}, 8'd0);
    n_compared++; if (fullness !== 8'd0) begin n_mismatch++; $display("FAIL len0_fullness: got %0d want 0", fullness); end
    send({128{1'b1}}, 8'd200);
    n_compared++; if (fullness !== 8'd128) begin n_mismatch++; $display("FAIL clamp_fullness: got %0d want 128", fullness); end
    @(posedge clk); #1;
    n_compared++; if (fullness !== 8'd0) begin n_mismatch++; $display("FAIL clamp_drained: got %0d want 0", fullness); end
    n_compared++; if (got_q.size() != exp_q.size()) begin n_mismatch++; $display("FAIL clamp_words: got %0d want %0d", got_q.size(), exp_q.size()); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      w_got = got_q.pop_front(); w_exp = exp_q.pop_front(); n_compared++;
      if (w_got !== w_exp) begin n_mismatch++; $display("FAIL clamp_word: got %h want %h", w_got, w_exp); end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_back_to_back();
    logic [127:0] d;
    logic [7:0]   l;
    int lat;
    bp_en = 1'b1;
    for (int k = 0; k < 40; k++) begin
      d = {$urandom, $urandom, $urandom, $urandom};
      l = 8'($urandom_range(0, 136));
      model_push(d, l);
      send(d, l);
    end
    bp_en = 1'b0;
    codec_data_full = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    model_flush();
    do_flush(lat);
    n_compared++; if (fullness !== 8'd0) begin n_mismatch++; $display("FAIL b2b_fullness: got %0d want 0", fullness); end
`ifdef BITPACK_BITCNT_EN
    n_compared++; if (pad_cnt !== model_pad) begin n_mismatch++; $display("FAIL b2b_pad_cnt: got %0d want %0d", pad_cnt, model_pad); end
`endif
    n_compared++; if (got_q.size() != exp_q.size()) begin n_mismatch++; $display("FAIL b2b_words: got %0d want %0d", got_q.size(), exp_q.size()); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      w_got = got_q.pop_front(); w_exp = exp_q.pop_front(); n_compared++;
      if (w_got !== w_exp) begin n_mismatch++; $display("FAIL b2b_word: got %h want %h", w_got, w_exp); end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_reset_mid();
    logic [127:0] z;
    z = {$urandom, $urandom, $urandom, $urandom};
    send({$urandom, $urandom, $urandom, $urandom}, 8'd90);
    n_compared++; if (fullness !== 8'd90) begin n_mismatch++; $display("FAIL rstmid_pre_fullness: got %0d want 90", fullness); end
`ifdef BITPACK_BITCNT_EN
    n_compared++; if (bit_cnt !== exp_bits) begin n_mismatch++; $display("FAIL rstmid_bit_cnt: got %0d want %0d", bit_cnt, exp_bits); end
`endif
    rstn = 1'b0;
    #2;
    n_compared++; if (fullness !== 8'd0) begin n_mismatch++; $display("FAIL rstmid_fullness: got %0d want 0", fullness); end
    n_compared++; if (codec_data_wr_en !== 1'b0 || codec_data !== 128'h0) begin n_mismatch++; $display("FAIL rstmid_out: wr_en=%b data=%h want 0 0", codec_data_wr_en, codec_data); end
    @(negedge clk); rstn = 1'b1;
    @(posedge clk); #1;
    exp_bits = 32'd0;
    n_compared++; if (got_q.size() != 0) begin n_mismatch++; $display("FAIL rstmid_spurious: got %0d words want 0", got_q.size()); end
    got_q.delete();
    exp_q.push_back(z);
    send(z, 8'd128);
    n_compared++; if (codec_data_wr_en !== 1'b1 || codec_data !== z) begin n_mismatch++; $display("FAIL rstmid_word: wr_en=%b data=%h want 1 %h", codec_data_wr_en, codec_data, z); end
`ifdef BITPACK_BITCNT_EN
    n_compared++; if (bit_cnt !== 32'd128) begin n_mismatch++; $display("FAIL rstmid_bit_cnt_after: got %0d want 128", bit_cnt); end
`endif
    @(posedge clk); #1;
    n_compared++; if (fullness !== 8'd0) begin n_mismatch++; $display("FAIL rstmid_drained: got %0d want 0", fullness); end
    n_compared++; if (got_q.size() != exp_q.size()) begin n_mismatch++; $display("FAIL rstmid_words: got %0d want %0d", got_q.size(), exp_q.size()); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      w_got = got_q.pop_front(); w_exp = exp_q.pop_front(); n_compared++;
      if (w_got !== w_exp) begin n_mismatch++; $display("FAIL rstmid_wordq: got %h want %h", w_got, w_exp); end
    end
    got_q.delete(); exp_q.delete();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    n_compared = 0;
    n_mismatch = 0;
    exp_bits   = 32'd0;
    test_reset();
    test_pack32();
    test_mixed_len();
    test_flush();
    test_flush_empty();
    test_backpressure();
    test_zero_clamp();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
    $finish;
  end

endmodule
